// File: rtl/plcp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plcp_pkg
// Purpose  : Shared types and constants for the PLCP frame parser: FSM state
//            encoding, SIGNAL field offsets, legal RATE table, default preamble.
// Revision : 1.0 - initial release
// ============================================================================
package plcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SIGNAL  = 3'd1,
    ST_SERVICE = 3'd2,
    ST_PSDU    = 3'd3,
    ST_TAIL    = 3'd4
  } state_t;

  // SIGNAL field layout, in received-bit positions
  localparam int c_rate_ofs   = 0;
  localparam int c_rate_w     = 4;
  localparam int c_rsvd_ofs   = 4;
  localparam int c_len_ofs    = 5;
  localparam int c_len_w      = 12;
  localparam int c_parity_ofs = 17;

  // Legal RATE codes as vectors, bit 0 = first received bit
  // (received order 1101,1111,0101,0111,1001,1011,0001,0011)
  localparam logic [3:0] c_legal_rates [8] = '{
    4'b1011, 4'b1111, 4'b1010, 4'b1110,
    4'b1001, 4'b1101, 4'b1000, 4'b1100
  };

  localparam logic [3:0]  c_rate_reset = 4'b1101;
  localparam logic [11:0] c_len_reset  = 12'h010;

  // Twelve 0xAA bytes, index 0 is the oldest bit
  localparam logic [0:95] c_default_preamble = {12{8'hAA}};

  function automatic logic rate_is_legal(input logic [3:0] rate);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rate == c_legal_rates[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plcp_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : plcp_frame_parser_if
// Purpose  : Serial input / decoded output bundle of the PLCP frame parser.
//            Signal suffixes are from the parser's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface plcp_frame_parser_if;
  logic        rx_bit_i;
  logic        rx_valid_i;
  logic        data_o;
  logic        data_valid_o;
  logic [3:0]  rate_o;
  logic [11:0] length_o;
  logic        header_valid_o;
  logic        parity_error_o;
  logic        rate_error_o;
  logic        frame_done_o;
  logic        busy_o;

  modport master (
    output rx_bit_i, rx_valid_i,
    input  data_o, data_valid_o, rate_o, length_o, header_valid_o,
           parity_error_o, rate_error_o, frame_done_o, busy_o
  );

  modport slave (
    input  rx_bit_i, rx_valid_i,
    output data_o, data_valid_o, rate_o, length_o, header_valid_o,
           parity_error_o, rate_error_o, frame_done_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/plcp_preamble_detect.sv
`default_nettype none
// ============================================================================
// Module   : plcp_preamble_detect
// Purpose  : Bit-history shift register and comparator. Flags a match in the
//            cycle whose sampled bit completes the pattern, then clears.
// Revision : 1.0 - initial release
// ============================================================================
module plcp_preamble_detect
  import plcp_pkg::*;
#(
  parameter int                       PREAMBLE_BITS    = 96,
  parameter logic [0:PREAMBLE_BITS-1] PREAMBLE_PATTERN = c_default_preamble
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en_i,
  input  wire logic valid_i,
  input  wire logic bit_i,
  output logic      match_o
);

  logic [0:PREAMBLE_BITS-1] hist_q, hist_d, shifted;

  // History register; index 0 holds the oldest bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end

  // Shift in sampled bits while searching; clear on a hit so a new frame
  // needs a full fresh preamble
  always_comb begin
    shifted = {hist_q[1:PREAMBLE_BITS-1], bit_i};
    match_o = en_i && valid_i && (shifted == PREAMBLE_PATTERN);
    hist_d  = hist_q;
    if (en_i && valid_i) hist_d = match_o ? '0 : shifted;
  end

endmodule
`default_nettype wire

// File: rtl/plcp_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : plcp_frame_parser
// Purpose  : Serial PLCP frame parser: preamble search, SIGNAL decode with
//            parity/rate checks, SERVICE skip, PSDU forwarding, tail skip.
// Revision : 1.0 - initial release
// ============================================================================
module plcp_frame_parser
  import plcp_pkg::*;
#(
  parameter int                       PREAMBLE_BITS    = 96,
  parameter logic [0:PREAMBLE_BITS-1] PREAMBLE_PATTERN = c_default_preamble,
  parameter int                       SERVICE_BITS     = 16,
  parameter int                       TAIL_BITS        = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  plcp_frame_parser_if.slave bus_io
);

  localparam logic [14:0] c_sig_last  = 15'(c_parity_ofs + TAIL_BITS);
  localparam logic [14:0] c_svc_last  = 15'(SERVICE_BITS - 1);
  localparam logic [14:0] c_tail_last = 15'(TAIL_BITS - 1);

  state_t                  state_q, state_d;
  logic [14:0]             cnt_q, cnt_d;
  logic [c_parity_ofs-1:0] sig_q, sig_d;
  logic [3:0]              rate_q, rate_d;
  logic [11:0]             len_q, len_d;
  logic                    data_q, data_d, dv_q, dv_d;
  logic                    hv_q, hv_d, pe_q, pe_d, re_q, re_d, fd_q, fd_d;
  logic                    match;
  logic                    parity_bad;
  logic [14:0]             psdu_last;

  plcp_preamble_detect #(
    .PREAMBLE_BITS   (PREAMBLE_BITS),
    .PREAMBLE_PATTERN(PREAMBLE_PATTERN)
  ) u_detect (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_IDLE),
    .valid_i(bus_io.rx_valid_i),
    .bit_i  (bus_io.rx_bit_i),
    .match_o(match)
  );

  assign parity_bad = ^{bus_io.rx_bit_i, sig_q};
  assign psdu_last  = {len_q, 3'b000} - 15'd1;

  // State, counters, latched header fields and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      rate_q  <= c_rate_reset;
      len_q   <= c_len_reset;
      data_q  <= 1'b0;
      dv_q    <= 1'b0;
      hv_q    <= 1'b0;
      pe_q    <= 1'b0;
      re_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      rate_q  <= rate_d;
      len_q   <= len_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      hv_q    <= hv_d;
      pe_q    <= pe_d;
      re_q    <= re_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic; nothing moves on cycles without a valid input bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    rate_d  = rate_q;
    len_d   = len_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    hv_d    = 1'b0;
    pe_d    = 1'b0;
    re_d    = 1'b0;
    fd_d    = 1'b0;
    if (bus_io.rx_valid_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d = ST_SIGNAL;
            cnt_d   = '0;
          end
        end
        ST_SIGNAL: begin
          cnt_d = cnt_q + 15'd1;
          if (cnt_q < 15'(c_parity_ofs)) sig_d[cnt_q[4:0]] = bus_io.rx_bit_i;
          if (cnt_q == 15'(c_parity_ofs) && parity_bad) begin
            pe_d    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == 15'(c_parity_ofs) &&
                       !rate_is_legal(sig_q[c_rate_ofs +: c_rate_w])) begin
            re_d    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == c_sig_last) begin
            rate_d  = sig_q[c_rate_ofs +: c_rate_w];
            len_d   = sig_q[c_len_ofs +: c_len_w];
            hv_d    = 1'b1;
            state_d = ST_SERVICE;
            cnt_d   = '0;
          end
        end
        ST_SERVICE: begin
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == c_svc_last) begin
            cnt_d   = '0;
            state_d = (len_q == 12'd0) ? ST_TAIL : ST_PSDU;
          end
        end
        ST_PSDU: begin
          data_d = bus_io.rx_bit_i;
          dv_d   = 1'b1;
          cnt_d  = cnt_q + 15'd1;
          if (cnt_q == psdu_last) begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end
        end
        ST_TAIL: begin
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == c_tail_last) begin
            cnt_d   = '0;
            fd_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus_io.data_o         = data_q;
  assign bus_io.data_valid_o   = dv_q;
  assign bus_io.rate_o         = rate_q;
  assign bus_io.length_o       = len_q;
  assign bus_io.header_valid_o = hv_q;
  assign bus_io.parity_error_o = pe_q;
  assign bus_io.rate_error_o   = re_q;
  assign bus_io.frame_done_o   = fd_q;
  assign bus_io.busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_plcp_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_plcp_frame_parser
// Purpose  : Self-checking bench for plcp_frame_parser. Frames are built from
//            their field values and outcomes predicted from the frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plcp_frame_parser;

  typedef logic [0:3] seq4_t;   // RATE bits in transmission order

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plcp_frame_parser_if bus();

  plcp_frame_parser dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [0:95] pat = {12{8'hAA}};
  seq4_t legal_tab [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                           4'b1001, 4'b1011, 4'b0001, 4'b0011};

  bit frame_q[$];
  bit psdu_q[$];
  bit out_q[$];
  bit saved_q[$];

  int n_hv = 0, n_pe = 0, n_re = 0, n_fd = 0;
  logic [3:0]  exp_rate = 4'b1101;
  logic [11:0] exp_len  = 12'h010;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid_o)   out_q.push_back(bus.data_o);
      if (bus.header_valid_o) n_hv++;
      if (bus.parity_error_o) n_pe++;
      if (bus.rate_error_o)   n_re++;
      if (bus.frame_done_o)   n_fd++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input seq4_t s);
    bit ok = 0;
    foreach (legal_tab[i]) if (legal_tab[i] == s) ok = 1;
    return ok;
  endfunction

  function automatic logic [3:0] seq_to_rate(input seq4_t s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = s[i];
    return r;
  endfunction

  task automatic gen_psdu(input int len);
    psdu_q.delete();
    for (int i = 0; i < 8 * len; i++) psdu_q.push_back(1'($urandom));
  endtask

  // Preamble + SIGNAL (+ SERVICE + PSDU + tail when body); cut>=0 stops PSDU early
  task automatic build(input seq4_t rs, input int len, input bit flip,
                       input bit body, input int cut);
    bit sig[$];
    bit p;
    int n;
    frame_q.delete();
    for (int i = 0; i < 96; i++) frame_q.push_back(pat[i]);
    for (int i = 0; i < 4; i++) sig.push_back(rs[i]);
    sig.push_back(1'($urandom));
    for (int i = 0; i < 12; i++) sig.push_back(len[i]);
    p = 0;
    foreach (sig[i]) p ^= sig[i];
    sig.push_back(p ^ flip);
    for (int i = 0; i < 6; i++) sig.push_back(1'b0);
    foreach (sig[i]) frame_q.push_back(sig[i]);
    if (body) begin
      for (int i = 0; i < 16; i++) frame_q.push_back(1'($urandom));
      n = (cut >= 0) ? cut : psdu_q.size();
      for (int i = 0; i < n; i++) frame_q.push_back(psdu_q[i]);
      if (cut < 0) for (int i = 0; i < 6; i++) frame_q.push_back(1'b0);
    end
  endtask

  task automatic send_bit(input bit b, input int duty);
    @(negedge clk);
    while ($urandom_range(99) >= duty) begin
      bus.rx_valid_i = 1'b0;
      bus.rx_bit_i   = 1'($urandom);
      @(negedge clk);
    end
    bus.rx_valid_i = 1'b1;
    bus.rx_bit_i   = b;
  endtask

  task automatic send_frame(input int duty);
    foreach (frame_q[i]) send_bit(frame_q[i], duty);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      bus.rx_bit_i   = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".data"}, bus.data_o, 0);
    chk({tag, ".dv"},   bus.data_valid_o, 0);
    chk({tag, ".rate"}, bus.rate_o, 4'b1101);
    chk({tag, ".len"},  bus.length_o, 12'h010);
    chk({tag, ".hv"},   bus.header_valid_o, 0);
    chk({tag, ".pe"},   bus.parity_error_o, 0);
    chk({tag, ".re"},   bus.rate_error_o, 0);
    chk({tag, ".fd"},   bus.frame_done_o, 0);
    chk({tag, ".busy"}, bus.busy_o, 0);
  endtask

  // One complete frame with outcome predicted from its fields
  task automatic run_frame(input string tag, input seq4_t rs, input int len,
                           input bit flip, input int duty, input bit regen);
    int b_hv, b_pe, b_re, b_fd, mism;
    bit ok;
    b_hv = n_hv; b_pe = n_pe; b_re = n_re; b_fd = n_fd;
    ok = !flip && is_legal(rs);
    if (regen) gen_psdu(len);
    out_q.delete();
    build(rs, len, flip, ok, -1);
    send_frame(duty);
    idle(4);
    if (ok) begin
      exp_rate = seq_to_rate(rs);
      exp_len  = 12'(len);
    end
    chk({tag, ".hv"},   n_hv - b_hv, ok);
    chk({tag, ".pe"},   n_pe - b_pe, flip);
    chk({tag, ".re"},   n_re - b_re, !flip && !is_legal(rs));
    chk({tag, ".fd"},   n_fd - b_fd, ok);
    chk({tag, ".ndv"},  out_q.size(), ok ? 8 * len : 0);
    mism = 0;
    if (ok) for (int i = 0; i < psdu_q.size(); i++)
      if (i >= out_q.size() || out_q[i] != psdu_q[i]) mism++;
    chk({tag, ".bits"}, mism, 0);
    chk({tag, ".rate"}, bus.rate_o, exp_rate);
    chk({tag, ".len"},  bus.length_o, exp_len);
    chk({tag, ".busy"}, bus.busy_o, 0);
  endtask

  initial begin
    int b_hv, b_fd, b_pe, b_re, mism;
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_bit_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    idle(2);

    // Basic good frame, full duty
    run_frame("good", 4'b1101, 2, 0, 100, 1);
    saved_q = out_q;

    // Parity flipped, header must hold previous values, then a good frame
    run_frame("parity", 4'b1101, 2, 1, 100, 1);
    run_frame("after_par", 4'b0011, 3, 0, 100, 1);

    // Illegal rate, and illegal rate with bad parity (parity wins)
    run_frame("rate0", 4'b0000, 2, 0, 100, 1);
    run_frame("rate_par", 4'b0000, 2, 1, 100, 1);

    // Zero-length PSDU
    run_frame("len0", 4'b1111, 0, 0, 100, 1);

    // Same PSDU as the first frame with about half the cycles invalid
    psdu_q = saved_q;
    run_frame("duty", 4'b1101, 2, 0, 50, 0);
    mism = (out_q.size() == saved_q.size()) ? 0 : 1;
    if (mism == 0) foreach (saved_q[i]) if (saved_q[i] != out_q[i]) mism++;
    chk("duty.same", mism, 0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      seq4_t rs;
      rs = 4'($urandom);
      run_frame($sformatf("rnd%0d", k), rs, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom_range(40, 100), 1);
    end

    // Reset in the middle of a PSDU carrying an embedded preamble
    b_hv = n_hv; b_fd = n_fd; b_pe = n_pe; b_re = n_re;
    psdu_q.delete();
    for (int i = 0; i < 8; i++)  psdu_q.push_back(1'($urandom));
    for (int i = 0; i < 96; i++) psdu_q.push_back(pat[i]);
    for (int i = 0; i < 24; i++) psdu_q.push_back(1'($urandom));
    out_q.delete();
    build(4'b1001, 16, 0, 1, 110);
    send_frame(100);
    idle(2);
    chk("mid.hv", n_hv - b_hv, 1);
    chk("mid.ndv", out_q.size(), 110);
    chk("mid.busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("midrst.fd", n_fd - b_fd, 0);
    chk("midrst.err", (n_pe - b_pe) + (n_re - b_re), 0);
    exp_rate = 4'b1101;
    exp_len  = 12'h010;
    run_frame("post_rst", 4'b0111, 1, 0, 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
